// File: rtl/irq_controller.sv
// irq_controller
//   Parametrised interrupt controller. Each raw source is synchronised,
//   edge-detected and latched into a pending register. Pending bits gated by
//   the mask are arbitrated (lowest index wins) and presented to the CPU as a
//   single request with an ID over a valid/ack handshake.
//
//   Optional feature macro: IRQ_CTRL_LEVEL_MODE_EN
//     Defined   : MODE register (addr 3) exists; MODE bit=1 makes that channel
//                 level-sensitive (pending follows the synchronised level).
//     Undefined : all channels edge-triggered, MODE reads 0, no MODE flops.
//
// Handshake (irq_valid / irq_id / irq_ack):
//   irq_valid is high only in REQ. While high, irq_id is stable and does not
//   change until the cycle irq_ack=1 is sampled. That ack clears the pending
//   bit of irq_id (a same-cycle edge on that channel wins), and irq_valid is
//   low for exactly one cycle (GAP) before the next grant can appear.
//   irq_ack sampled while irq_valid=0 has no effect.
//
// Ports:
//   clk        system clock
//   nreset     asynchronous active-low reset
//   irq_in     raw interrupt sources (may be asynchronous)
//   irq_valid  request to CPU
//   irq_id     granted channel index, meaningful while irq_valid=1
//   irq_ack    CPU accepts the current request
//   reg_addr   register select: 0 PENDING(W1C), 1 MASK, 2 FORCE(W1S), 3 MODE
//   reg_we     register write strobe
//   reg_wdata  register write data
//   reg_rdata  registered read data (1-cycle latency, follows reg_addr)
//   dbg_state  arbitration FSM state (0 IDLE, 1 REQ, 2 GAP)

module irq_controller #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int ID_W        = ($clog2(N_IRQ) < 1) ? 1 : $clog2(N_IRQ)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic [N_IRQ-1:0] irq_in,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  input  logic             irq_ack,
  input  logic [1:0]       reg_addr,
  input  logic             reg_we,
  input  logic [N_IRQ-1:0] reg_wdata,
  output logic [N_IRQ-1:0] reg_rdata,
  output logic [1:0]       dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [1:0] A_PENDING = 2'd0;
  localparam logic [1:0] A_MASK    = 2'd1;
  localparam logic [1:0] A_FORCE   = 2'd2;
  localparam logic [1:0] A_MODE    = 2'd3;

  // ---------------------------------------------------------------------------
  // Input synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] prev_q;
  logic [N_IRQ-1:0] sync_level;
  logic [N_IRQ-1:0] edge_det;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
      prev_q <= '0;
    end else begin
      sync_q[0] <= irq_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_level = sync_q[SYNC_STAGES-1];
  assign edge_det   = sync_level & ~prev_q;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [N_IRQ-1:0] rdata_q, rdata_d;
  logic [N_IRQ-1:0] mode;
  logic [N_IRQ-1:0] force_bits;
  logic [N_IRQ-1:0] w1c_bits;
  logic [N_IRQ-1:0] ack_bits;
  logic [N_IRQ-1:0] pend_edge;

  logic [1:0]       state_q, state_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  lowest_id;
  logic             ack_take;

  assign force_bits = (reg_we && reg_addr == A_FORCE)   ? reg_wdata : '0;
  assign w1c_bits   = (reg_we && reg_addr == A_PENDING) ? reg_wdata : '0;
  assign ack_take   = (state_q == ST_REQ) && irq_ack;
  assign ack_bits   = ack_take ? (N_IRQ'(1) << id_q) : '0;

  // Sets are OR-ed in after clears so a same-cycle edge is never lost.
  assign pend_edge  = (pending_q & ~(w1c_bits | ack_bits)) | edge_det | force_bits;

`ifdef IRQ_CTRL_LEVEL_MODE_EN
  logic [N_IRQ-1:0] mode_q, mode_d;

  always_comb begin
    mode_d = mode_q;
    if (reg_we && reg_addr == A_MODE) begin
      mode_d = reg_wdata;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      mode_q <= '0;
    end else begin
      mode_q <= mode_d;
    end
  end

  assign mode = mode_q;

  // Level channels track the synchronised input (plus force); ack and W1C
  // cannot clear them while the input is high.
  assign pending_d = (pend_edge & ~mode_q) | (mode_q & (sync_level | force_bits));
`else
  assign mode      = '0;
  assign pending_d = pend_edge;
`endif

  always_comb begin
    mask_d = mask_q;
    if (reg_we && reg_addr == A_MASK) begin
      mask_d = reg_wdata;
    end
  end

  // Read data is registered and follows reg_addr every cycle.
  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      A_PENDING: rdata_d = pending_q;
      A_MASK:    rdata_d = mask_q;
      A_FORCE:   rdata_d = '0;
      A_MODE:    rdata_d = mode;
      default:   rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pending_q <= '0;
      mask_q    <= '0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      mask_q    <= mask_d;
      rdata_q   <= rdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign eligible = pending_q & mask_q;

  // Index 0 is the highest priority: scan downwards so the lowest set bit
  // is the last assignment.
  always_comb begin
    lowest_id = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        lowest_id = ID_W'(i);
      end
    end
  end

  // GAP holds irq_valid low for the ack'd cycle's successor; the grant
  // decision taken on leaving GAP is the same re-arbitration IDLE performs,
  // so back-to-back requests see exactly one low cycle.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (|eligible) begin
          state_d = ST_REQ;
          id_d    = lowest_id;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (irq_ack) begin
          state_d = ST_GAP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  assign irq_valid = (state_q == ST_REQ);
  assign irq_id    = id_q;
  assign reg_rdata = rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_controller.sv
// Testbench for irq_controller (N_IRQ=8, SYNC_STAGES=2).
// A behavioural model tracks the input history, pending/mask/mode contents
// and the outstanding grant; a compare process checks the DUT against it on
// every falling edge. Directed sequences add hand-computed literal checks.

module tb_irq_controller;

  localparam int N    = 8;
  localparam int SS   = 2;
  localparam int ID_W = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic           clk = 1'b0;
  logic           nreset = 1'b0;
  logic [N-1:0]   irq_in = '0;
  logic           irq_ack = 1'b0;
  logic [1:0]     reg_addr = 2'd0;
  logic           reg_we = 1'b0;
  logic [N-1:0]   reg_wdata = '0;
  logic           irq_valid;
  logic [ID_W-1:0] irq_id;
  logic [N-1:0]   reg_rdata;
  logic [1:0]     dbg_state;

  always #10 clk = ~clk;

  irq_controller #(.N_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clk       (clk),
    .nreset    (nreset),
    .irq_in    (irq_in),
    .irq_valid (irq_valid),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check
  // ---------------------------------------------------------------------------
  int total  = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  //   in_hist[0] is the most recent sampled irq_in; a source is "seen" once
  //   it has travelled SS samples, and an edge is seen-now & not-seen-before.
  //   m_busy/m_id describe the outstanding request to the CPU.
  // ---------------------------------------------------------------------------
  logic [N-1:0] in_hist [$];
  logic [N-1:0] m_pend, m_mask, m_mode, m_rdata;
  logic [N-1:0] m_edges, m_level, m_set, m_clr, m_elig, m_force, m_next;
  bit           m_busy;
  int           m_id;

  task automatic model_reset();
    in_hist.delete();
    for (int i = 0; i <= SS; i++) in_hist.push_back('0);
    m_pend = '0; m_mask = '0; m_mode = '0; m_rdata = '0;
    m_busy = 1'b0; m_id = 0;
  endtask

  task automatic model_step();
    m_edges = in_hist[SS-1] & ~in_hist[SS];
    m_level = in_hist[SS-1];
    case (reg_addr)
      2'd0: m_rdata = m_pend;
      2'd1: m_rdata = m_mask;
      2'd3: m_rdata = m_mode;
      default: m_rdata = '0;
    endcase
    m_elig  = m_pend & m_mask;
    m_force = (reg_we && reg_addr == 2'd2) ? reg_wdata : '0;
    m_clr   = (reg_we && reg_addr == 2'd0) ? reg_wdata : '0;
    if (m_busy && irq_ack) m_clr[m_id] = 1'b1;
    m_set  = m_edges | m_force;
    m_next = (m_pend & ~m_clr) | m_set;
    for (int i = 0; i < N; i++) begin
      if (m_mode[i]) m_next[i] = m_level[i] | m_force[i];
    end
    m_pend = m_next;
    if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata;
`ifdef IRQ_CTRL_LEVEL_MODE_EN
    if (reg_we && reg_addr == 2'd3) m_mode = reg_wdata;
`endif
    if (m_busy) begin
      if (irq_ack) m_busy = 1'b0;
    end else if (m_elig != '0) begin
      m_busy = 1'b1;
      for (int i = N - 1; i >= 0; i--) if (m_elig[i]) m_id = i;
    end
    in_hist.push_front(irq_in);
    void'(in_hist.pop_back());
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge nreset);
      if (!nreset) model_reset();
      else model_step();
    end
  end

  // Compare process: outputs are stable at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("irq_valid", {31'd0, irq_valid}, {31'd0, m_busy});
        if (m_busy) check("irq_id", {29'd0, irq_id}, m_id);
        check("reg_rdata", {24'd0, reg_rdata}, {24'd0, m_rdata});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (all drive on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [N-1:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_addr = 2'd0; reg_wdata = '0;
  endtask

  task automatic do_ack();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int max_cycles);
    int n;
    n = 0;
    while (!irq_valid && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, {31'd0, irq_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------------------
  // Directed sequences
  // ---------------------------------------------------------------------------
  initial begin
    tick(3);
    check("reset_valid", {31'd0, irq_valid}, 32'd0);
    check("reset_id", {29'd0, irq_id}, 32'd0);
    check("reset_rdata", {24'd0, reg_rdata}, 32'd0);
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    nreset = 1'b1;
    chk_en = 1'b1;
    tick();

    // 1: single pulse on channel 0, mask 0x01
    reg_write(2'd1, 8'h01);
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    check("t1_not_yet_a", {31'd0, irq_valid}, 32'd0);
    tick();
    check("t1_not_yet_b", {31'd0, irq_valid}, 32'd0);
    tick();
    check("t1_valid", {31'd0, irq_valid}, 32'd1);
    check("t1_id", {29'd0, irq_id}, 32'd0);
    check("t1_pending", {24'd0, reg_rdata}, 32'h01);
    do_ack();
    check("t1_gap", {31'd0, irq_valid}, 32'd0);
    tick();
    check("t1_idle", {31'd0, irq_valid}, 32'd0);
    check("t1_pending_clr", {24'd0, reg_rdata}, 32'h00);

    // 2: channels 5 and 2 together
    reg_write(2'd1, 8'hFF);
    irq_in = 8'h24;
    wait_valid("t2_wait_a", 10);
    check("t2_id_a", {29'd0, irq_id}, 32'd2);
    do_ack();
    check("t2_gap", {31'd0, irq_valid}, 32'd0);
    tick();
    check("t2_valid_b", {31'd0, irq_valid}, 32'd1);
    check("t2_id_b", {29'd0, irq_id}, 32'd5);
    do_ack();
    tick();
    check("t2_idle", {31'd0, irq_valid}, 32'd0);
    check("t2_pending", {24'd0, reg_rdata}, 32'h00);
    irq_in = 8'h00;
    tick(3);

    // 3: higher-priority arrival while in REQ
    irq_in = 8'h08;
    wait_valid("t3_wait", 10);
    check("t3_id_a", {29'd0, irq_id}, 32'd3);
    irq_in = 8'h0A;
    tick(5);
    check("t3_hold_valid", {31'd0, irq_valid}, 32'd1);
    check("t3_hold_id", {29'd0, irq_id}, 32'd3);
    do_ack();
    check("t3_gap", {31'd0, irq_valid}, 32'd0);
    tick();
    check("t3_id_b", {29'd0, irq_id}, 32'd1);
    do_ack();
    irq_in = 8'h00;
    tick(4);

    // 4: new edge on ch 4 in the same cycle as the ack of id 4
    irq_in = 8'h10;
    wait_valid("t4_wait", 10);
    check("t4_id_a", {29'd0, irq_id}, 32'd4);
    irq_in = 8'h00;
    tick(4);
    irq_in = 8'h10;
    tick(2);
    do_ack();
    check("t4_gap", {31'd0, irq_valid}, 32'd0);
    tick();
    check("t4_regrant", {31'd0, irq_valid}, 32'd1);
    check("t4_id_b", {29'd0, irq_id}, 32'd4);
    check("t4_pending", {24'd0, reg_rdata}, 32'h10);
    do_ack();
    irq_in = 8'h00;
    tick(4);

    // 5: masked pending, enable via MASK, FORCE, W1C during REQ
    reg_write(2'd1, 8'h00);
    irq_in = 8'h40;
    tick(6);
    check("t5_masked_valid", {31'd0, irq_valid}, 32'd0);
    check("t5_masked_pending", {24'd0, reg_rdata}, 32'h40);
    reg_write(2'd1, 8'h40);
    tick();
    check("t5_valid", {31'd0, irq_valid}, 32'd1);
    check("t5_id", {29'd0, irq_id}, 32'd6);
    reg_write(2'd2, 8'h80);
    tick();
    check("t5_force", {24'd0, reg_rdata}, 32'hC0);
    reg_write(2'd0, 8'hC0);
    check("t5_w1c_hold", {31'd0, irq_valid}, 32'd1);
    tick();
    check("t5_w1c_hold2", {31'd0, irq_valid}, 32'd1);
    check("t5_w1c_pending", {24'd0, reg_rdata}, 32'h00);
    do_ack();
    tick(3);
    check("t5_after_ack", {31'd0, irq_valid}, 32'd0);
    irq_in = 8'h00;

    // MODE register read-back
    reg_write(2'd3, 8'h01);
    reg_addr = 2'd3;
    tick();
`ifdef IRQ_CTRL_LEVEL_MODE_EN
    check("mode_read", {24'd0, reg_rdata}, 32'h01);
`else
    check("mode_read", {24'd0, reg_rdata}, 32'h00);
`endif
    reg_addr = 2'd0;
    tick(2);

    // 6: reset during REQ
    reg_write(2'd1, 8'h01);
    reg_write(2'd2, 8'h01);
    wait_valid("t6_wait", 6);
    check("t6_id", {29'd0, irq_id}, 32'd0);
    #2 nreset = 1'b0;
    #1 check("t6_async_valid", {31'd0, irq_valid}, 32'd0);
    tick();
    nreset = 1'b1;
    reg_addr = 2'd1;
    tick();
    check("t6_mask", {24'd0, reg_rdata}, 32'h00);
    reg_addr = 2'd0;
    tick();
    check("t6_pending", {24'd0, reg_rdata}, 32'h00);
    do_ack();
    tick();
    check("t6_ack_ignored", {31'd0, irq_valid}, 32'd0);

`ifdef IRQ_CTRL_LEVEL_MODE_EN
    // Level channel 0: repeated grants while the input is held high
    reg_write(2'd3, 8'h01);
    reg_write(2'd1, 8'h01);
    irq_in = 8'h01;
    for (int k = 0; k < 3; k++) begin
      wait_valid("lvl_wait", 8);
      check("lvl_id", {29'd0, irq_id}, 32'd0);
      do_ack();
      check("lvl_gap", {31'd0, irq_valid}, 32'd0);
    end
    irq_in = 8'h00;
    tick(3);
    if (irq_valid) do_ack();
    tick(4);
    check("lvl_done", {31'd0, irq_valid}, 32'd0);
`endif

    tick(2);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
